line_setup_unit: RTL

- Front-end stage of the Bresenham line engine; sits directly upstream of error_unit and the x counter.
- Accepts raw endpoints (x0,y0)-(x1,y1) through a req/ready handshake, then runs a multi-cycle FSM that resolves the steep flag and swaps endpoints into canonical left-to-right, shallow form.
- Computes deltax, deltay, ystep and initial error, pulses start to the downstream units, waits for last_count, then reports done.

---
 rtl/line_setup_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/line_setup_unit.sv
// Bresenham front end: captures raw endpoints, folds the line into the shallow
// left-to-right octant, derives deltas/ystep/initial error and sequences start/done.
module line_setup_unit #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] x0_in,
  input  logic [WIDTH-1:0] y0_in,
  input  logic [WIDTH-1:0] x1_in,
  input  logic [WIDTH-1:0] y1_in,
  input  logic             last_count,
  output logic             ready,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] deltax,
  output logic [WIDTH-1:0] deltay,
  output logic [WIDTH-1:0] ystep,
  output logic [WIDTH-1:0] error_init,
  output logic             steep,
  output logic             start,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ABS, S_SWAP1, S_SWAP2, S_DELTA, S_START, S_RUN, S_DONE
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0] wx0, wy0, wx1, wy1;
  logic signed [WIDTH:0]   dx_ext, dy_ext, adx, ady;

  // Differences are taken one bit wider so the magnitude compare cannot wrap.
  always_comb begin
    dx_ext = {wx1[WIDTH-1], wx1} - {wx0[WIDTH-1], wx0};
    dy_ext = {wy1[WIDTH-1], wy1} - {wy0[WIDTH-1], wy0};
    adx    = dx_ext[WIDTH] ? -dx_ext : dx_ext;
    ady    = dy_ext[WIDTH] ? -dy_ext : dy_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (req) state_next = S_ABS;
      end
      S_ABS:   state_next = S_SWAP1;
      S_SWAP1: state_next = S_SWAP2;
      S_SWAP2: state_next = S_DELTA;
      S_DELTA: state_next = S_START;
      S_START: begin
        start      = 1'b1;
        state_next = last_count ? S_DONE : S_RUN;
      end
      S_RUN: if (last_count) state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Working endpoints are rewritten in place as the line is canonicalised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wx0        <= '0;
      wy0        <= '0;
      wx1        <= '0;
      wy1        <= '0;
      steep      <= 1'b0;
      x0         <= '0;
      x1         <= '0;
      y0         <= '0;
      deltax     <= '0;
      deltay     <= '0;
      ystep      <= '0;
      error_init <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            wx0 <= x0_in;
            wy0 <= y0_in;
            wx1 <= x1_in;
            wy1 <= y1_in;
          end
        end
        S_ABS: steep <= ($unsigned(ady) > $unsigned(adx));
        S_SWAP1: begin
          if (steep) begin
            wx0 <= wy0;
            wy0 <= wx0;
            wx1 <= wy1;
            wy1 <= wx1;
          end
        end
        S_SWAP2: begin
          if (wx0 > wx1) begin
            wx0 <= wx1;
            wx1 <= wx0;
            wy0 <= wy1;
            wy1 <= wy0;
          end
        end
        S_DELTA: begin
          x0         <= wx0;
          x1         <= wx1;
          y0         <= wy0;
          deltax     <= dx_ext[WIDTH-1:0];
          deltay     <= ady[WIDTH-1:0];
          ystep      <= (wy0 < wy1) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
          error_init <= $signed(dx_ext[WIDTH-1:0]) >>> 1;
        end
        default: ;
      endcase
    end
  end

endmodule
